// File: rtl/csi_rx_clk_mon_pkg.sv
// Shared defaults and counter-width helpers for the multi-channel byte-clock monitor.
package csi_rx_clk_mon_pkg;

  // Bits needed to hold values 0..maxval.
  function automatic int unsigned cnt_bits(input int unsigned maxval);
    return (maxval < 2) ? 1 : $clog2(maxval + 1);
  endfunction

  localparam int unsigned DEF_N_CH       = 2;
  localparam int unsigned DEF_TIMEOUT    = 10;
  localparam int unsigned DEF_WINDOW     = 1024;
  localparam int unsigned DEF_CNT_W      = 12;
  localparam int unsigned DEF_FREQ_MIN   = 240;
  localparam int unsigned DEF_FREQ_MAX   = 272;
  localparam int unsigned DEF_OK_WINDOWS = 2;
  localparam int unsigned DEF_RST_HOLD   = 2;

  localparam int unsigned DEF_GAP_W  = cnt_bits(DEF_TIMEOUT);
  localparam int unsigned DEF_WIN_W  = cnt_bits(DEF_WINDOW - 1);
  localparam int unsigned DEF_HOLD_W = cnt_bits(DEF_RST_HOLD + 1);

endpackage

// File: rtl/csi_rx_clk_mon_ch.sv
// One monitored byte clock: toggle/sync/edge, gap timeout, window count,
// clk_ok hysteresis, sticky loss flag and byte-domain reset hold.
module csi_rx_clk_mon_ch
  import csi_rx_clk_mon_pkg::*;
#(
  parameter int unsigned TIMEOUT    = DEF_TIMEOUT,
  parameter int unsigned CNT_W      = DEF_CNT_W,
  parameter int unsigned FREQ_MIN   = DEF_FREQ_MIN,
  parameter int unsigned FREQ_MAX   = DEF_FREQ_MAX,
  parameter int unsigned OK_WINDOWS = DEF_OK_WINDOWS,
  parameter int unsigned RST_HOLD   = DEF_RST_HOLD
) (
  input  logic             ref_clock,
  input  logic             reset_in_demet,
  input  logic             byte_clock_i,
  input  logic             enable_i,
  input  logic             clr_sticky_i,
  input  logic             win_last_i,
  output logic             reset_out_o,
  output logic             clk_ok_o,
  output logic             clk_lost_sticky_o,
  output logic [CNT_W-1:0] freq_cnt_o
);

  localparam int unsigned GAP_W  = cnt_bits(TIMEOUT);
  localparam int unsigned OK_W   = cnt_bits(OK_WINDOWS);
  localparam int unsigned HOLD_W = cnt_bits(RST_HOLD + 1);

  logic [1:0]        brst_q;
  logic              byte_rst;
  logic              tog_q;
  logic [2:0]        sync_q;
  logic              edge_det;
  logic [GAP_W-1:0]  gap_q, gap_d;
  logic              fail_q, fail_d;
  logic [CNT_W-1:0]  acc_q, acc_d, acc_inc;
  logic [CNT_W-1:0]  freq_q, freq_d;
  logic              in_range;
  logic [OK_W-1:0]   ok_cnt_q, ok_cnt_d;
  logic              clk_ok_q, clk_ok_d;
  logic              sticky_q, sticky_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              rst_out_q;

  // Byte-domain reset for tog only; reset_out must not stop the toggle.
  always_ff @(posedge byte_clock_i or posedge reset_in_demet) begin
    if (reset_in_demet) brst_q <= '1;
    else                brst_q <= {brst_q[0], 1'b0};
  end

  assign byte_rst = brst_q[1];

  always_ff @(posedge byte_clock_i or posedge byte_rst) begin
    if (byte_rst) tog_q <= 1'b0;
    else          tog_q <= ~tog_q;
  end

  assign edge_det = sync_q[2] ^ sync_q[1];

  always_comb begin
    gap_d = gap_q;
    if (edge_det)                   gap_d = '0;
    else if (gap_q < GAP_W'(TIMEOUT)) gap_d = gap_q + 1'b1;
    fail_d = (gap_q >= GAP_W'(TIMEOUT));

    acc_inc  = (edge_det && (acc_q != '1)) ? acc_q + 1'b1 : acc_q;
    in_range = (acc_inc >= CNT_W'(FREQ_MIN)) && (acc_inc <= CNT_W'(FREQ_MAX));
    acc_d    = win_last_i ? '0 : acc_inc;
    freq_d   = win_last_i ? acc_inc : freq_q;

    ok_cnt_d = ok_cnt_q;
    if (win_last_i) begin
      if (!in_range)                        ok_cnt_d = '0;
      else if (ok_cnt_q < OK_W'(OK_WINDOWS)) ok_cnt_d = ok_cnt_q + 1'b1;
    end
    if (fail_q) ok_cnt_d = '0;

    // clk_ok_q tracks (ok_cnt_q == OK_WINDOWS && !fail_q) so the fall is
    // visible on the same edge that updates the sticky flag.
    clk_ok_d = (ok_cnt_d == OK_W'(OK_WINDOWS)) && !fail_d;

    sticky_d = sticky_q;
    if (clr_sticky_i)           sticky_d = 1'b0;
    if (clk_ok_q && !clk_ok_d) sticky_d = 1'b1;
  end

  always_ff @(posedge ref_clock or posedge reset_in_demet) begin
    if (reset_in_demet) begin
      sync_q   <= '0;
      gap_q    <= '0;
      fail_q   <= 1'b1;
      acc_q    <= '0;
      freq_q   <= '0;
      ok_cnt_q <= '0;
      clk_ok_q <= 1'b0;
      sticky_q <= 1'b0;
    end else begin
      sync_q   <= {sync_q[1:0], tog_q};
      gap_q    <= gap_d;
      fail_q   <= fail_d;
      acc_q    <= acc_d;
      freq_q   <= freq_d;
      ok_cnt_q <= ok_cnt_d;
      clk_ok_q <= clk_ok_d;
      sticky_q <= sticky_d;
    end
  end

  always_comb begin
    hold_d = hold_q;
    if (enable_i && rst_out_q && (hold_q != '1)) hold_d = hold_q + 1'b1;
  end

  // fail_q asserts reset_out asynchronously; release is counted in byte cycles.
  always_ff @(posedge byte_clock_i or posedge fail_q) begin
    if (fail_q) begin
      hold_q    <= '0;
      rst_out_q <= 1'b1;
    end else begin
      hold_q    <= hold_d;
      rst_out_q <= (hold_q < HOLD_W'(RST_HOLD));
    end
  end

  assign reset_out_o       = rst_out_q;
  assign clk_ok_o          = clk_ok_q;
  assign clk_lost_sticky_o = sticky_q;
  assign freq_cnt_o        = freq_q;

endmodule

// File: rtl/csi_rx_clk_mon.sv
// Multi-channel CSI-2 RX byte-clock monitor: shared measurement window,
// per-channel monitors and output packing.
module csi_rx_clk_mon
  import csi_rx_clk_mon_pkg::*;
#(
  parameter int unsigned N_CH       = DEF_N_CH,
  parameter int unsigned TIMEOUT    = DEF_TIMEOUT,
  parameter int unsigned WINDOW     = DEF_WINDOW,
  parameter int unsigned CNT_W      = DEF_CNT_W,
  parameter int unsigned FREQ_MIN   = DEF_FREQ_MIN,
  parameter int unsigned FREQ_MAX   = DEF_FREQ_MAX,
  parameter int unsigned OK_WINDOWS = DEF_OK_WINDOWS,
  parameter int unsigned RST_HOLD   = DEF_RST_HOLD
) (
  input  logic                  ref_clock,
  input  logic                  reset_in_demet,
  input  logic [N_CH-1:0]       byte_clock,
  input  logic [N_CH-1:0]       enable,
  input  logic                  clr_sticky,
  output logic [N_CH-1:0]       reset_out,
  output logic [N_CH-1:0]       clk_ok,
  output logic [N_CH-1:0]       clk_lost_sticky,
  output logic [N_CH*CNT_W-1:0] freq_cnt,
  output logic                  freq_valid
);

  localparam int unsigned WIN_W = cnt_bits(WINDOW - 1);

  logic [WIN_W-1:0] win_q, win_d;
  logic             win_last;
  logic             freq_valid_q;

  always_comb begin
    win_last = (win_q == WIN_W'(WINDOW - 1));
    win_d    = win_last ? '0 : win_q + 1'b1;
  end

  always_ff @(posedge ref_clock or posedge reset_in_demet) begin
    if (reset_in_demet) begin
      win_q        <= '0;
      freq_valid_q <= 1'b0;
    end else begin
      win_q        <= win_d;
      freq_valid_q <= win_last;
    end
  end

  assign freq_valid = freq_valid_q;

  for (genvar g = 0; g < N_CH; g++) begin : gen_ch
    csi_rx_clk_mon_ch #(
      .TIMEOUT    (TIMEOUT),
      .CNT_W      (CNT_W),
      .FREQ_MIN   (FREQ_MIN),
      .FREQ_MAX   (FREQ_MAX),
      .OK_WINDOWS (OK_WINDOWS),
      .RST_HOLD   (RST_HOLD)
    ) u_ch (
      .ref_clock         (ref_clock),
      .reset_in_demet    (reset_in_demet),
      .byte_clock_i      (byte_clock[g]),
      .enable_i          (enable[g]),
      .clr_sticky_i      (clr_sticky),
      .win_last_i        (win_last),
      .reset_out_o       (reset_out[g]),
      .clk_ok_o          (clk_ok[g]),
      .clk_lost_sticky_o (clk_lost_sticky[g]),
      .freq_cnt_o        (freq_cnt[g*CNT_W +: CNT_W])
    );
  end

endmodule

// File: tb/tb_csi_rx_clk_mon.sv
// Directed bench: ref 200 MHz, byte[0] 50 MHz (256/window), byte[1] 40 MHz (~205/window).
`timescale 1ns/100ps
module tb_csi_rx_clk_mon;

  logic        ref_clock = 1'b0;
  logic        reset_in_demet;
  logic        bclk0 = 1'b0, bclk1 = 1'b0;
  logic        run0 = 1'b1, run1 = 1'b1;
  logic [1:0]  enable;
  logic        clr_sticky;
  logic [1:0]  reset_out, clk_ok, clk_lost_sticky;
  logic [23:0] freq_cnt;
  logic        freq_valid;

  int checks = 0;
  int errors = 0;

  csi_rx_clk_mon #(
    .N_CH (2), .TIMEOUT (10), .WINDOW (1024), .CNT_W (12),
    .FREQ_MIN (240), .FREQ_MAX (272), .OK_WINDOWS (2), .RST_HOLD (2)
  ) dut (
    .ref_clock       (ref_clock),
    .reset_in_demet  (reset_in_demet),
    .byte_clock      ({bclk1, bclk0}),
    .enable          (enable),
    .clr_sticky      (clr_sticky),
    .reset_out       (reset_out),
    .clk_ok          (clk_ok),
    .clk_lost_sticky (clk_lost_sticky),
    .freq_cnt        (freq_cnt),
    .freq_valid      (freq_valid)
  );

  initial forever #2.5 ref_clock = ~ref_clock;
  // Byte clocks offset by 1.3 ns so no edge coincides with a ref edge.
  initial begin #1.3; forever begin #10;   if (run0) bclk0 = ~bclk0; end end
  initial begin #1.3; forever begin #12.5; if (run1) bclk1 = ~bclk1; end end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic ref_cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge ref_clock);
  endtask

  task automatic wait_valid(input string tag);
    logic got;
    got = 1'b0;
    for (int i = 0; i < 1100; i++) begin
      @(negedge ref_clock);
      if (freq_valid) begin got = 1'b1; break; end
    end
    check(tag, {31'd0, got}, 32'd1);
  endtask

  // Counts byte edges of the selected channel until its reset_out falls.
  task automatic release_edges(input int ch, output int n);
    n = 99;
    for (int i = 1; i <= 10; i++) begin
      if (ch == 0) @(posedge bclk0); else @(posedge bclk1);
      #1;
      if (!reset_out[ch]) begin n = i; break; end
    end
  endtask

  // Stops byte[0] just after a rising edge; counts ref negedges until reset_out[0].
  task automatic stop_ch0(output int n);
    @(posedge bclk0);
    run0 = 1'b0;
    n = 99;
    for (int i = 1; i <= 30; i++) begin
      @(negedge ref_clock);
      if (reset_out[0]) begin n = i; break; end
    end
  endtask

  int n;
  logic [11:0] f0, f1;

  initial begin
    reset_in_demet = 1'b1;
    enable         = 2'b00;
    clr_sticky     = 1'b0;
    ref_cycles(10);
    check("rst_reset_out",  {30'd0, reset_out}, 32'h3);
    check("rst_clk_ok",     {30'd0, clk_ok}, 32'h0);
    check("rst_sticky",     {30'd0, clk_lost_sticky}, 32'h0);
    check("rst_freq_cnt",   {8'd0, freq_cnt}, 32'h0);
    check("rst_freq_valid", {31'd0, freq_valid}, 32'h0);

    reset_in_demet = 1'b0;
    ref_cycles(40);
    check("gated_reset_out", {30'd0, reset_out}, 32'h3);

    @(posedge bclk0); #1 enable[0] = 1'b1;
    release_edges(0, n);
    check("release_edges_ch0", n, 3);
    @(posedge bclk1); #1 enable[1] = 1'b1;
    release_edges(1, n);
    check("release_edges_ch1", n, 3);

    wait_valid("valid_timeout_w1");
    check("clk_ok_after_w1", {30'd0, clk_ok}, 32'h0);
    @(negedge ref_clock);
    check("freq_valid_pulse", {31'd0, freq_valid}, 32'h0);
    wait_valid("valid_timeout_w2");
    wait_valid("valid_timeout_w3");
    f0 = freq_cnt[11:0];
    f1 = freq_cnt[23:12];
    check("freq_cnt0_256", {31'd0, (f0 >= 12'd255 && f0 <= 12'd257)}, 32'd1);
    check("freq_cnt1_205", {31'd0, (f1 >= 12'd204 && f1 <= 12'd206)}, 32'd1);
    check("clk_ok_locked", {30'd0, clk_ok}, 32'h1);
    check("reset_out_both_released", {30'd0, reset_out}, 32'h0);

    stop_ch0(n);
    check("loss_latency_le14", {31'd0, (n <= 14)}, 32'd1);
    check("loss_clk_ok", {30'd0, clk_ok}, 32'h0);
    check("loss_sticky", {30'd0, clk_lost_sticky}, 32'h1);
    check("ch1_reset_out_unaffected", {31'd0, reset_out[1]}, 32'd0);
    clr_sticky = 1'b1;
    @(negedge ref_clock);
    clr_sticky = 1'b0;
    check("sticky_cleared", {30'd0, clk_lost_sticky}, 32'h0);

    run0 = 1'b1;
    wait_valid("valid_timeout_r1");
    wait_valid("valid_timeout_r2");
    wait_valid("valid_timeout_r3");
    check("relock_clk_ok", {30'd0, clk_ok}, 32'h1);

    clr_sticky = 1'b1;
    stop_ch0(n);
    check("collision_latency", {31'd0, (n <= 14)}, 32'd1);
    check("collision_set_wins", {30'd0, clk_lost_sticky}, 32'h1);
    @(negedge ref_clock);
    check("collision_clr_after", {30'd0, clk_lost_sticky}, 32'h0);
    clr_sticky = 1'b0;

    run0 = 1'b1;
    wait_valid("valid_timeout_s1");
    wait_valid("valid_timeout_s2");
    wait_valid("valid_timeout_s3");
    check("pre_reset_clk_ok", {30'd0, clk_ok}, 32'h1);
    ref_cycles(300);
    #1 reset_in_demet = 1'b1;
    #1;
    check("midrst_reset_out",  {30'd0, reset_out}, 32'h3);
    check("midrst_clk_ok",     {30'd0, clk_ok}, 32'h0);
    check("midrst_freq_cnt",   {8'd0, freq_cnt}, 32'h0);
    check("midrst_freq_valid", {31'd0, freq_valid}, 32'h0);
    ref_cycles(5);
    reset_in_demet = 1'b0;
    wait_valid("valid_timeout_m1");
    wait_valid("valid_timeout_m2");
    wait_valid("valid_timeout_m3");
    check("post_reset_clk_ok", {30'd0, clk_ok}, 32'h1);
    check("post_reset_reset_out", {30'd0, reset_out}, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/csi_rx_clk_mon.md
# csi_rx_clk_mon

Multi-channel successor of the CSI-2 RX byte-clock detector. It watches `N_CH` independent byte clocks from the ref_clock domain and reports per channel:
- loss of clock, via a gap timeout;
- frequency, via a windowed transition count against a min/max band, with hysteresis.

Each channel also drives a byte-domain reset that holds its lane logic until the clock has been stable for `RST_HOLD` cycles. It sits between the D-PHY clock lanes and the per-camera `csi_rx` lane/packet logic.

## Interface
Parameters:
- `N_CH`, 2, number of monitored byte clocks.
- `TIMEOUT`, 10, ref_clock cycles without a transition before fail (≥3).
- `WINDOW`, 1024, ref_clock cycles per frequency-measurement window.
- `CNT_W`, 12, width of the per-channel transition count; must hold `WINDOW/2`.
- `FREQ_MIN`, 240, minimum in-range count per window (inclusive).
- `FREQ_MAX`, 272, maximum in-range count per window (inclusive).
- `OK_WINDOWS`, 2, consecutive in-range windows needed to assert `clk_ok`.
- `RST_HOLD`, 2, byte_clock cycles with enable=1 before `reset_out` releases.

Ports:
- `ref_clock` in 1: monitor clock.
- `reset_in_demet` in 1: reset, asynchronous, active-high, in the ref_clock domain.
- `byte_clock` in `N_CH`: monitored clocks; each bit is its own clock domain.
- `enable` in `N_CH`: per-channel release enable, sampled in its byte_clock domain.
- `clr_sticky` in 1: ref domain, clears `clk_lost_sticky`.
- `reset_out` out `N_CH`: bit i is a reset for byte_clock[i] logic, active-high.
- `clk_ok` out `N_CH`: ref domain; clock present and in band.
- `clk_lost_sticky` out `N_CH`: ref domain; latched loss event.
- `freq_cnt` out `N_CH*CNT_W`: last window's transition count, channel i at `[i*CNT_W +: CNT_W]`.
- `freq_valid` out 1: one-cycle pulse when `freq_cnt` updates.

## Operation
Per channel i:
- **Toggle generation.**
  - `tog[i]` toggles on every byte_clock[i] rising edge, converting the clock into data.
  - `tog` is reset by a 2-flop byte-domain synchroniser of `reset_in_demet` (async assert, sync deassert).
  - `tog` must NOT be reset by `reset_out`: that would freeze `tog` and deadlock recovery.
- **Synchronisation and edge detect.**
  - `tog` passes through a 2-flop synchroniser into ref_clock, then a third flop for edge detection.
  - `edge` = XOR of the last two stages.
- **Gap counter.**
  - Cleared to 0 on `edge`; otherwise increments, saturating at `TIMEOUT`.
  - `fail` is registered as `gap >= TIMEOUT`. Reset value of `fail` is 1.
- **Frequency window.**
  - A shared ref counter runs 0..`WINDOW-1`; all channels share the window.
  - A per-channel accumulator counts `edge` pulses, saturating at all-ones.
  - On the last window cycle: `freq_cnt[i]` ← accumulator plus the current edge; the accumulator restarts at 0; `freq_valid` pulses the next cycle.
  - A window is in-range if `FREQ_MIN ≤ count ≤ FREQ_MAX`.
- **`clk_ok` hysteresis.**
  - A consecutive in-range window counter saturates at `OK_WINDOWS`.
  - An out-of-range window or `fail`=1 clears the counter immediately.
  - `clk_ok` = counter==`OK_WINDOWS` && !`fail`.
- **`clk_lost_sticky`.**
  - Set on the cycle `clk_ok` falls 1→0.
  - Cleared by `clr_sticky`; set wins if both occur in the same cycle.
- **`reset_out`.**
  - `fail` asynchronously clears the byte-domain hold counter.
  - The counter increments on byte_clock[i] while `enable[i]` && `reset_out[i]`, saturating.
  - `reset_out[i]` is registered as `hold_cnt < RST_HOLD`.
  - Frequency out-of-band does not assert `reset_out`; it is reported only.

## Timing
- **Reset values:**
  - `reset_out` = all 1.
  - `clk_ok` = 0, `clk_lost_sticky` = 0.
  - `freq_cnt` = 0, `freq_valid` = 0.
  - `fail` = 1, all counters 0.
- **Valid input range:** byte_clock frequency ≤ ref_clock/3; above this, transitions alias and counts are undefined.
- **Loss detection latency:** from the last byte edge to `fail`=1 is at most `TIMEOUT` + 4 ref cycles (2 sync, 1 edge, 1 compare).
- **`clk_ok` rise:** ≥ `OK_WINDOWS` full windows after `fail` clears. A partial first window after reset counts as a normal window and normally fails the band.
- **`reset_out` release:** `RST_HOLD`+1 byte cycles after `fail` deasserts (as seen at the byte domain) with enable high. Assertion is asynchronous, within the `fail` flop's clock-to-out delay.
- **`enable` low mid-hold:** the counter holds its value and `reset_out` stays 1.
- **`reset_in_demet` mid-window:** all ref state returns to reset values at once, and any window in progress is discarded.

## Structure
- Package `csi_rx_clk_mon_pkg`: default parameter constants and the `$clog2`-derived widths for the gap, window and hold counters.
- One sub-module `csi_rx_clk_mon_ch`: a single channel (toggle, synchronisers, gap, accumulator, hysteresis, `reset_out`), instantiated `N_CH` times by a generate loop.
- The top level holds the shared window counter, the `freq_valid` pulse and the output packing.

## Test plan
- **Nominal lock.** ref 200 MHz, byte[0] 50 MHz, enable=1 → `fail` clears within 10 cycles; `reset_out[0]` falls 3 byte cycles later; `freq_cnt[0]`=256±1 each window; `clk_ok[0]`=1 after the 2nd full window.
- **Clock stop.** byte[0] stops mid-window → `fail` within 14 ref cycles; `reset_out[0]` asserts asynchronously; `clk_ok[0]` falls; `clk_lost_sticky[0]`=1; `clr_sticky` clears it.
- **Out of band.** byte[1] at 40 MHz (count≈205) → `clk_ok[1]` stays 0 while `reset_out[1]` releases; channel 0 is unaffected.
- **Enable gating.** enable[0]=0 with the clock running → `reset_out[0]` stays 1; raising enable releases it after 3 byte cycles.
- **Reset mid-operation.** Pulse `reset_in_demet` while locked → all outputs return to reset values within 1 ref cycle (async); re-lock follows the nominal timing.
- **Sticky set/clear collision.** `clr_sticky` in the same cycle `clk_ok` falls → `clk_lost_sticky` remains 1.
